// File: rtl/matmul_pkg.sv
// Shared matmul definitions: matrix geometry, word packing order and drain types.
package matmul_pkg;

  localparam int MM_DATA_WIDTH = 16;
  localparam int MM_ROWS       = 64;
  localparam int MM_COLS       = 64;
  // 32-bit output words per matrix row
  localparam int MM_WPR        = MM_COLS * MM_DATA_WIDTH / 32;

  // High half of each 32-bit word carries the even element (2j), low half 2j+1
  localparam bit MM_PACK_HI_EVEN = 1'b1;

  // FIFO entry: word plus frame and row markers
  localparam int DRAIN_ENTRY_W = 34;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    FLUSH  = 2'd2,
    FINISH = 2'd3
  } drain_state_t;

  typedef struct packed {
    logic [31:0] data;
    logic        tlast;
    logic        row_last;
  } drain_entry_t;

  // Present a BRAM word with the even element in the high half
  function automatic logic [31:0] pack_word(input logic [31:0] w);
    return MM_PACK_HI_EVEN ? w : {w[15:0], w[31:16]};
  endfunction

endpackage

// File: rtl/matmul_drain_fifo.sv
// Synchronous register FIFO with occupancy count; absorbs BRAM read latency.
module matmul_drain_fifo #(
  parameter int DEPTH = 3,
  parameter int WIDTH = matmul_pkg::DRAIN_ENTRY_W,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_V  = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_V);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; reset flushes the FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are qualified by count, so no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/matmul_result_drain.sv
// Drains the matmul output buffer in row-major order as a valid/ready stream
// with row/frame markers; reads are credit-limited so the FIFO never overflows.
module matmul_result_drain #(
  parameter int DATA_WIDTH   = matmul_pkg::MM_DATA_WIDTH,
  parameter int ROWS         = matmul_pkg::MM_ROWS,
  parameter int COLS         = matmul_pkg::MM_COLS,
  parameter int ADDR_WIDTH   = 11,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk_a,
  input  logic                  rst,
  input  logic                  done,
  output logic                  en_out_axi,
  output logic [3:0]            we_out_axi,
  output logic [ADDR_WIDTH-1:0] addr_out_axi,
  input  logic [31:0]           dout_out_axi,
  output logic [31:0]           m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  m_row_last,
  output logic                  busy,
  output logic                  drain_done
);

  import matmul_pkg::*;

  localparam int WPR        = COLS * DATA_WIDTH / 32;
  localparam int TOTAL      = ROWS * WPR;
  localparam int FIFO_DEPTH = READ_LATENCY + 2;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int WC_W       = $clog2(TOTAL) + 1;

  localparam logic [CNT_W:0]  DEPTH_V   = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(TOTAL - 1);
  localparam logic [WC_W-1:0] WPR_V     = WC_W'(WPR);
  localparam logic [WC_W-1:0] ROW_END   = WC_W'(WPR - 1);

  drain_state_t             state;
  drain_state_t             state_nxt;
  logic                     done_q;
  logic                     trigger;
  logic [WC_W-1:0]          rd_cnt;
  logic [WC_W-1:0]          wr_cnt;
  logic [READ_LATENCY-1:0]  rd_vld_p;
  logic [CNT_W-1:0]         inflight;
  logic [CNT_W-1:0]         fifo_count;
  logic [CNT_W:0]           occupancy;
  logic                     credit_ok;
  logic                     issue;
  logic                     push;
  logic                     pop;
  logic                     fifo_empty;
  drain_entry_t             push_entry;
  drain_entry_t             head_entry;
  logic [DRAIN_ENTRY_W-1:0] head_bits;

  assign trigger   = done & ~done_q;
  assign issue     = (state == READ) & credit_ok;
  assign push      = rd_vld_p[READ_LATENCY-1];
  assign pop       = m_tvalid & m_tready;
  assign occupancy = {1'b0, inflight} + {1'b0, fifo_count};
  assign credit_ok = occupancy < DEPTH_V;
  assign head_entry = drain_entry_t'(head_bits);

  assign en_out_axi   = issue;
  assign we_out_axi   = 4'b0000;
  assign addr_out_axi = rd_cnt[ADDR_WIDTH-1:0];

  // Reads still in the BRAM pipeline hold a credit until they land in the FIFO
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + CNT_W'(rd_vld_p[i]);
    end
  end

  // Markers come from the count of returned words, not from the address
  always_comb begin
    push_entry.data     = pack_word(dout_out_axi);
    push_entry.tlast    = (wr_cnt == LAST_WORD);
    push_entry.row_last = ((wr_cnt % WPR_V) == ROW_END);
  end

  // Edge detector; starts high so a done already asserted at reset is not a trigger
  always_ff @(posedge clk_a) begin
    if (rst) done_q <= 1'b1;
    else     done_q <= done;
  end

  // Issue/return counters and the read-valid shift register (stage p0 .. pN)
  always_ff @(posedge clk_a) begin
    if (rst) begin
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      rd_vld_p <= '0;
    end else begin
      if ((state == IDLE) && trigger) begin
        rd_cnt <= '0;
        wr_cnt <= '0;
      end else begin
        if (issue) rd_cnt <= rd_cnt + 1'b1;
        if (push)  wr_cnt <= wr_cnt + 1'b1;
      end
      rd_vld_p <= (rd_vld_p << 1) | READ_LATENCY'(issue);
    end
  end

  // BRAM data return boundary: words enter the FIFO when their read valid emerges
  matmul_drain_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DRAIN_ENTRY_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk_a),
    .rst   (rst),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head_bits),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // FSM state register
  always_ff @(posedge clk_a) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state: a done edge outside IDLE is ignored
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trigger) state_nxt = READ;
      READ:    if (issue && (rd_cnt == LAST_WORD)) state_nxt = FLUSH;
      FLUSH:   if (pop && head_entry.tlast) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: stream fields are forced to zero whenever no word is offered
  always_comb begin
    busy       = (state == READ) || (state == FLUSH);
    drain_done = (state == FINISH);
    m_tvalid   = busy && !fifo_empty;
    m_tdata    = m_tvalid ? head_entry.data : '0;
    m_tlast    = m_tvalid && head_entry.tlast;
    m_row_last = m_tvalid && head_entry.row_last;
  end

endmodule

// File: tb/tb_matmul_result_drain.sv
// Directed bench for matmul_result_drain: two instances (read latency 1 and 2)
// share clock, reset, done and ready, each backed by a BRAM model returning
// its own address as data.
module tb_matmul_result_drain;

  logic        clk;
  logic        rst;
  logic        done;
  logic        ready;

  logic        en_a, tvalid_a, tlast_a, rowl_a, busy_a, ddone_a;
  logic [3:0]  we_a;
  logic [10:0] addr_a;
  logic [31:0] dout_a, tdata_a;

  logic        en_b, tvalid_b, tlast_b, rowl_b, busy_b, ddone_b;
  logic [3:0]  we_b;
  logic [10:0] addr_b;
  logic [31:0] dout_b, tdata_b, pipe_b;

  int          compared;
  int          mismatched;
  int          cnt_a, cnt_b, pulses_a, pulses_b;
  logic        stall_a, stall_b;
  logic [33:0] hold_a, hold_b;

  matmul_result_drain #(.READ_LATENCY(1)) dut_a (
    .clk_a(clk), .rst(rst), .done(done),
    .en_out_axi(en_a), .we_out_axi(we_a), .addr_out_axi(addr_a), .dout_out_axi(dout_a),
    .m_tdata(tdata_a), .m_tvalid(tvalid_a), .m_tready(ready), .m_tlast(tlast_a),
    .m_row_last(rowl_a), .busy(busy_a), .drain_done(ddone_a)
  );

  matmul_result_drain #(.READ_LATENCY(2)) dut_b (
    .clk_a(clk), .rst(rst), .done(done),
    .en_out_axi(en_b), .we_out_axi(we_b), .addr_out_axi(addr_b), .dout_out_axi(dout_b),
    .m_tdata(tdata_b), .m_tvalid(tvalid_b), .m_tready(ready), .m_tlast(tlast_b),
    .m_row_last(rowl_b), .busy(busy_b), .drain_done(ddone_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM models: word content equals its address
  always @(posedge clk) begin
    if (en_a) dout_a <= {21'd0, addr_a};
  end

  always @(posedge clk) begin
    if (en_b) pipe_b <= {21'd0, addr_b};
    dout_b <= pipe_b;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stream scoreboard, sampled on the falling edge
  task automatic monitor();
    if (rst) begin
      stall_a = 1'b0;
      stall_b = 1'b0;
    end else begin
      if (stall_a) check("hold_a", {tvalid_a, tdata_a, tlast_a, rowl_a}, {1'b1, hold_a});
      if (tvalid_a && ready) begin
        check("data_a", tdata_a, cnt_a);
        check("mark_a", {tlast_a, rowl_a}, {cnt_a == 2047, cnt_a % 32 == 31});
        cnt_a++;
      end
      stall_a = tvalid_a && !ready;
      hold_a  = {tdata_a, tlast_a, rowl_a};
      if (ddone_a) pulses_a++;
      check("fifo_a", dut_a.u_fifo.count <= 3, 1'b1);

      if (stall_b) check("hold_b", {tvalid_b, tdata_b, tlast_b, rowl_b}, {1'b1, hold_b});
      if (tvalid_b && ready) begin
        check("data_b", tdata_b, cnt_b);
        check("mark_b", {tlast_b, rowl_b}, {cnt_b == 2047, cnt_b % 32 == 31});
        cnt_b++;
      end
      stall_b = tvalid_b && !ready;
      hold_b  = {tdata_b, tlast_b, rowl_b};
      if (ddone_b) pulses_b++;
      check("fifo_b", dut_b.u_fifo.count <= 4, 1'b1);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_drain();
    done = 1'b0;
    tick(1);
    cnt_a = 0; cnt_b = 0; pulses_a = 0; pulses_b = 0;
    done = 1'b1;
  endtask

  task automatic wait_finish(input string tag, input bit rnd);
    for (int i = 0; i < 30000 && !(pulses_a >= 1 && pulses_b >= 1); i++) begin
      ready = rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
      tick(1);
    end
    check({tag, "_timeout"}, (pulses_a >= 1 && pulses_b >= 1), 1'b1);
    ready = 1'b1;
    tick(5);
    check({tag, "_words_a"}, cnt_a, 2048);
    check({tag, "_words_b"}, cnt_b, 2048);
    check({tag, "_pulses_a"}, pulses_a, 1);
    check({tag, "_pulses_b"}, pulses_b, 1);
    check({tag, "_idle"}, {busy_a, busy_b, tvalid_a, tvalid_b}, 4'b0);
  endtask

  task automatic wait_words(input string tag, input int n);
    for (int i = 0; i < 5000 && cnt_a < n; i++) tick(1);
    check({tag, "_timeout"}, cnt_a >= n, 1'b1);
  endtask

  initial begin
    compared = 0; mismatched = 0;
    cnt_a = 0; cnt_b = 0; pulses_a = 0; pulses_b = 0;
    stall_a = 1'b0; stall_b = 1'b0; hold_a = '0; hold_b = '0;
    rst = 1'b1; done = 1'b0; ready = 1'b1;

    // Reset values
    tick(3);
    check("rst_a", {en_a, we_a, addr_a, tvalid_a, tdata_a, tlast_a, rowl_a, busy_a, ddone_a}, 53'd0);
    check("rst_b", {en_b, we_b, addr_b, tvalid_b, tdata_b, tlast_b, rowl_b, busy_b, ddone_b}, 53'd0);
    rst = 1'b0;
    tick(3);
    check("idle_a", {busy_a, en_a, tvalid_a}, 3'b0);

    // Free-flow drain with cycle-exact latency
    start_drain();
    tick(1);
    check("c1_a", {busy_a, en_a, addr_a, tvalid_a}, {1'b1, 1'b1, 11'd0, 1'b0});
    check("c1_b", {busy_b, en_b, addr_b, tvalid_b}, {1'b1, 1'b1, 11'd0, 1'b0});
    tick(1);
    check("c2_a", {en_a, addr_a, tvalid_a}, {1'b1, 11'd1, 1'b0});
    check("c2_b", tvalid_b, 1'b0);
    tick(1);
    check("c3_a", {tvalid_a, tdata_a}, {1'b1, 32'd0});
    check("c3_b", tvalid_b, 1'b0);
    tick(1);
    check("c4_b", {tvalid_b, tdata_b}, {1'b1, 32'd0});
    tick(2046);
    check("last_a", {tvalid_a, tdata_a, tlast_a, rowl_a, ddone_a, busy_a},
          {1'b1, 32'd2047, 1'b1, 1'b1, 1'b0, 1'b1});
    tick(1);
    check("done_a", {ddone_a, busy_a, tvalid_a}, 3'b100);
    check("last_b", {tvalid_b, tdata_b, tlast_b, ddone_b}, {1'b1, 32'd2047, 1'b1, 1'b0});
    tick(1);
    check("pulse_end_a", ddone_a, 1'b0);
    check("done_b", {ddone_b, busy_b}, 2'b10);
    wait_finish("free", 1'b0);

    // Backpressure: ready high 30% of cycles
    start_drain();
    wait_finish("bp", 1'b1);

    // Second done edge mid-drain is ignored
    start_drain();
    wait_words("retrig", 500);
    done = 1'b0;
    tick(1);
    done = 1'b1;
    wait_finish("retrig", 1'b0);
    tick(10);
    check("retrig_no_second", {pulses_a == 1, busy_a, busy_b}, 3'b100);

    // Reset mid-drain with done held high
    start_drain();
    wait_words("middrain", 1000);
    rst = 1'b1;
    tick(1);
    check("midrst_a", {en_a, we_a, addr_a, tvalid_a, tdata_a, tlast_a, rowl_a, busy_a, ddone_a}, 53'd0);
    check("midrst_b", {en_b, we_b, addr_b, tvalid_b, tdata_b, tlast_b, rowl_b, busy_b, ddone_b}, 53'd0);
    tick(2);
    rst = 1'b0;
    pulses_a = 0; pulses_b = 0;
    tick(10);
    check("no_redrain", {busy_a, busy_b, tvalid_a, tvalid_b, en_a, en_b}, 6'b0);
    check("no_redrain_pulse", pulses_a + pulses_b, 0);
    start_drain();
    tick(1);
    check("restart_c1", {busy_a, en_a, addr_a}, {1'b1, 1'b1, 11'd0});
    tick(2);
    check("restart_c3", {tvalid_a, tdata_a}, {1'b1, 32'd0});
    wait_finish("restart", 1'b0);

    // Reset released while done is already high
    rst = 1'b1;
    done = 1'b1;
    tick(2);
    rst = 1'b0;
    pulses_a = 0; pulses_b = 0;
    tick(10);
    check("done_high_rst", {busy_a, busy_b, en_a, en_b, tvalid_a, tvalid_b}, 6'b0);
    check("done_high_pulse", pulses_a + pulses_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/matmul_result_drain.md
# matmul_result_drain

Result-side drain stage that sits directly downstream of `Matmul_top`. On the rising edge of `done` it reads the 64x64 output buffer through the 32-bit output BRAM port in row-major word order. It presents the words as a valid/ready stream with row and frame markers, so the PS-side DMA no longer polls `addr_out_axi` by hand. Backpressure is absorbed by a small credit-controlled FIFO that covers the BRAM read latency.

## Interface
Parameters:
- `DATA_WIDTH`, 16, element width; two elements are packed per 32-bit word.
- `ROWS`, 64, output rows.
- `COLS`, 64, output columns; words per row `WPR = COLS*DATA_WIDTH/32` (32).
- `ADDR_WIDTH`, 11, output BRAM word-address width; `ROWS*WPR` must equal `2**ADDR_WIDTH`.
- `READ_LATENCY`, 1, BRAM cycles from `en_out_axi`/address to valid `dout_out_axi` (1 or 2).

Ports:
- `clk_a`, in, 1, single clock; the output-BRAM PS-side port runs on this clock.
- `rst`, in, 1, **synchronous, active-high** reset.
- `done`, in, 1, level done flag from `Matmul_top`.
- `en_out_axi`, out, 1, output BRAM port enable.
- `we_out_axi`, out, 4, constant `4'b0000` (read-only).
- `addr_out_axi`, out, `ADDR_WIDTH`, output BRAM word address.
- `dout_out_axi`, in, 32, BRAM read data.
- `m_tdata`, out, 32, stream word; `[31:16]` = element 2j, `[15:0]` = element 2j+1.
- `m_tvalid`, out, 1, stream valid.
- `m_tready`, in, 1, stream ready.
- `m_tlast`, out, 1, high on the final word of the frame (word `ROWS*WPR-1`).
- `m_row_last`, out, 1, high on the last word of each row (`addr % WPR == WPR-1`).
- `busy`, out, 1, high from trigger until `drain_done`.
- `drain_done`, out, 1, one-cycle pulse after the final handshake.

## Operation
- Trigger: `done & ~done_q`. `done_q` resets to **1**, so a `done` that is already high when reset releases does not start a drain.
- A `done` rising edge while `busy` is high is ignored.
- FSM states:
  - `IDLE`: waits for the trigger, which clears the read/write counters and goes to `READ`.
  - `READ`: issues reads while credits are available.
  - `FLUSH`: entered after the last address is issued; waits until the FIFO is empty and the final word has handshaken.
  - `FINISH`: pulses `drain_done` for one cycle, then returns to `IDLE`.
- Credit rule: a read is issued (`en_out_axi=1`, address increments) only when `inflight + fifo_count < FIFO_DEPTH`, where `FIFO_DEPTH = READ_LATENCY+2`. The FIFO therefore never overflows, and no word is lost or duplicated under any `m_tready` pattern.
- `inflight` is tracked with a `READ_LATENCY`-deep valid shift register; returning data is pushed into the FIFO.
- Handshake:
  - A word transfers when `m_tvalid & m_tready`.
  - Once asserted, `m_tvalid`, `m_tdata`, `m_tlast` and `m_row_last` hold stable until the transfer.
  - `m_tvalid` is never asserted in `IDLE`.
- Markers are derived from a read-side word counter carried through the FIFO, not from the BRAM address.
- Address wraps naturally at `2**ADDR_WIDTH`; reads stop after exactly `ROWS*WPR` issues.

## Timing
- Reset values:
  - `en_out_axi=0`, `we_out_axi=0`, `addr_out_axi=0`.
  - `m_tvalid=0`, `m_tdata=0`, `m_tlast=0`, `m_row_last=0`.
  - `busy=0`, `drain_done=0`.
  - FIFO empty, state `IDLE`.
- Cycle 0: trigger sampled. Cycle 1: `busy=1`, first read (`addr=0`).
- With `m_tready` held high:
  - First `m_tvalid` at cycle `2+READ_LATENCY`.
  - One word per cycle thereafter.
  - Last word at cycle `2+READ_LATENCY+2047`.
  - `drain_done` the cycle after the last handshake; `busy` drops with it.
- `rst` mid-drain: all outputs return to reset values on the next edge and the FIFO is flushed. The next drain needs a fresh `done` rising edge.
- `m_tready` low for N cycles stalls `addr_out_axi` within `FIFO_DEPTH` issues. Reads resume one cycle after credits free.

## Structure
- A shared package `matmul_pkg` holds `DATA_WIDTH`, `ROWS`, `COLS`, the derived `WPR`, and the packing-order constant (high half = even element). `Matmul_top` and this block use the same definitions.
- One sub-module: `matmul_drain_fifo`, a synchronous register FIFO of depth `FIFO_DEPTH` with 34-bit entries (data plus `tlast` and `row_last`) and a `count` output.

## Test plan
- Free-flow: BRAM model word = address, `READ_LATENCY=1`, `m_tready=1`, pulse `done` → 2048 words 0..2047 in order; `m_row_last` on words 31, 63, …, 2047; `m_tlast` only on word 2047; `drain_done` one cycle later.
- Backpressure: `m_tready` random at 30% → same 2048-word sequence, no gaps or duplicates; `m_tdata` stable while `m_tvalid & ~m_tready`; FIFO count never exceeds 3.
- Latency 2: `READ_LATENCY=2`, `m_tready=1` → first `m_tvalid` at cycle 4 after trigger; full sequence correct.
- Retrigger ignore: second `done` rising edge at word 500 → still exactly 2048 words and one `drain_done` pulse.
- Reset mid-drain: assert `rst` at word 1000 with `done` held high → all outputs 0 next cycle; no drain after release until `done` toggles low then high, after which words restart at 0.
- Reset with `done` already high → no drain, `busy=0`.
